// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store sequencer.
// State encoding, access size codes and big-endian byte-lane shift amounts.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Big-endian: byte offset 0 is the most significant lane.
  localparam logic [4:0] SHIFT_B0 = 5'd24;
  localparam logic [4:0] SHIFT_B1 = 5'd16;
  localparam logic [4:0] SHIFT_B2 = 5'd8;
  localparam logic [4:0] SHIFT_B3 = 5'd0;
  localparam logic [4:0] SHIFT_H0 = 5'd16;
  localparam logic [4:0] SHIFT_H2 = 5'd0;

  function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] off);
    logic [4:0] sh;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    sh = SHIFT_B0;
          2'd1:    sh = SHIFT_B1;
          2'd2:    sh = SHIFT_B2;
          2'd3:    sh = SHIFT_B3;
          default: sh = SHIFT_B3;
        endcase
      end
      SZ_HALF: sh = off[1] ? SHIFT_H2 : SHIFT_H0;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  // Drops the low offset bits that lie below the natural alignment of the access.
  function automatic logic [1:0] align_offset(input logic [1:0] sz, input logic [1:0] off);
    logic [1:0] a;
    case (sz)
      SZ_BYTE: a = off;
      SZ_HALF: a = {off[1], 1'b0};
      default: a = 2'b00;
    endcase
    return a;
  endfunction

  function automatic logic misaligned_access(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction with sign/zero extension, and sub-word lane merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [4:0]  shift_s;
  logic [31:0] lane_s;
  logic [31:0] mask_s;
  logic [31:0] ins_s;

  // Extract the addressed lane for loads and splice the store lane into the word.
  always_comb begin
    shift_s  = lane_shift(size, offset);
    lane_s   = word >> shift_s;
    load_ext = lane_s;
    mask_s   = 32'hFFFF_FFFF;
    ins_s    = store_data;
    case (size)
      SZ_BYTE: begin
        load_ext = {{24{sign_ext & lane_s[7]}}, lane_s[7:0]};
        mask_s   = 32'h0000_00FF << shift_s;
        ins_s    = {24'h00_0000, store_data[7:0]} << shift_s;
      end
      SZ_HALF: begin
        load_ext = {{16{sign_ext & lane_s[15]}}, lane_s[15:0]};
        mask_s   = 32'h0000_FFFF << shift_s;
        ins_s    = {16'h0000, store_data[15:0]} << shift_s;
      end
      default: begin
        load_ext = lane_s;
        mask_s   = 32'hFFFF_FFFF;
        ins_s    = store_data;
      end
    endcase
    merged = (word & ~mask_s) | (ins_s & mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store sequencer in front of a word-addressed memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] byte_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e  state_r;
  logic        is_store_r;
  logic [1:0]  size_r;
  logic        sign_ext_r;
  logic [1:0]  offset_r;
  logic [31:0] store_data_r;
  logic        trap_s;
  logic [31:0] load_ext_s;
  logic [31:0] merged_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = misaligned_access(size, byte_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  lsu_lane_align u_align (
    .word       (mem_read_data),
    .size       (size_r),
    .offset     (offset_r),
    .sign_ext   (sign_ext_r),
    .store_data (store_data_r),
    .load_ext   (load_ext_s),
    .merged     (merged_s)
  );

  // Sequencer FSM; every output is registered and cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      is_store_r     <= 1'b0;
      size_r         <= SZ_BYTE;
      sign_ext_r     <= 1'b0;
      offset_r       <= 2'b00;
      store_data_r   <= 32'h0000_0000;
      busy           <= 1'b0;
      done           <= 1'b0;
      load_data      <= 32'h0000_0000;
      misaligned     <= 1'b0;
      mem_addr       <= 32'h0000_0000;
      mem_write_data <= 32'h0000_0000;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            is_store_r   <= is_store;
            size_r       <= size;
            sign_ext_r   <= sign_ext;
            offset_r     <= align_offset(size, byte_addr[1:0]);
            store_data_r <= store_data;
            mem_addr     <= 32'(byte_addr >> 2);
            misaligned   <= trap_s;
            busy         <= 1'b1;
            if (trap_s) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else if (is_store && size[1]) begin
              mem_write_data <= store_data;
              mem_write      <= 1'b1;
              state_r        <= ST_WR;
            end else begin
              mem_read <= 1'b1;
              state_r  <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_r <= ST_CAP;
        end
        ST_CAP: begin
          // Read data is valid now; a sub-word store turns around into a write.
          mem_read <= 1'b0;
          if (is_store_r) begin
            mem_write_data <= merged_s;
            mem_write      <= 1'b1;
            state_r        <= ST_WR;
          end else begin
            load_data <= load_ext_s;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_WR: begin
          mem_write <= 1'b0;
          done      <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] byte_addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_load = 32'h0;
  logic        mem_clr;
  logic [31:0] mem [0:15];

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .is_store       (is_store),
    .size           (size),
    .sign_ext       (sign_ext),
    .byte_addr      (byte_addr),
    .store_data     (store_data),
    .busy           (busy),
    .done           (done),
    .load_data      (load_data),
    .misaligned     (misaligned),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, synchronous write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem_read_data <= 32'h0;
    end else begin
      if (mem_read) mem_read_data <= mem[mem_addr[3:0]];
      if (mem_write) mem[mem_addr[3:0]] <= mem_write_data;
    end
  end

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
    end
    if (mem_read && mem_write) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: mem_read=%0b mem_write=%0b, required not both high", mem_read, mem_write);
    end
    if (done) begin
      done_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (load_data !== e.ld || misaligned !== e.mis || cyc !== e.cyc) begin
          errors++;
          $display("FAIL done_result: load_data=%h misaligned=%0b cycle=%0d, required %h %0b %0d",
                   load_data, misaligned, cyc, e.ld, e.mis, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_ld, input logic exp_mis, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; is_store = st; size = sz; sign_ext = sx; byte_addr = a; store_data = d;
    e.ld = exp_ld; e.mis = exp_mis; e.cyc = cyc + lat;
    sb_q.push_back(e);
    last_load = exp_ld;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_clr = 1'b1;
    start = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    byte_addr = 32'h0; store_data = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, misaligned, mem_write, mem_read} !== 5'b00000 ||
        load_data !== 32'h0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: flags=%b ld=%h addr=%h wd=%h, required 00000 0 0 0",
               {busy, done, misaligned, mem_write, mem_read}, load_data, mem_addr, mem_write_data);
    end
    rst = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    // Preload word 1 through the unit itself.
    issue(1'b1, 2'b10, 1'b0, 32'd4, 32'h8000_00F0, 32'h0, 1'b0, 2);
    checks++;
    if (mem[1] !== 32'h8000_00F0) begin
      errors++;
      $display("FAIL preload: mem[1]=%h, required 800000f0", mem[1]);
    end
  endtask

  task automatic test_byte_loads();
    issue(1'b0, 2'b00, 1'b1, 32'd7, 32'h0, 32'hFFFF_FFF0, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'd7, 32'h0, 32'h0000_00F0, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 32'h0000_0080, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b1, 32'd5, 32'h0, 32'h0000_0000, 1'b0, 3);
  endtask

  task automatic test_half_store();
    int r0;
    int w0;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'd6, 32'h1234_BEEF, last_load, 1'b0, 4);
    checks++;
    if (mem[1] !== 32'h8000_BEEF || rd_cnt - r0 != 2 || wr_cnt - w0 != 1) begin
      errors++;
      $display("FAIL half_store: mem[1]=%h reads=%0d writes=%0d, required 8000beef 2 1",
               mem[1], rd_cnt - r0, wr_cnt - w0);
    end
    issue(1'b0, 2'b01, 1'b1, 32'd4, 32'h0, 32'hFFFF_8000, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b0, 32'd6, 32'h0, 32'h0000_BEEF, 1'b0, 3);
  endtask

  task automatic test_word_store();
    int r0;
    int w0;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h0000_0008, last_load, 1'b0, 2);
    checks++;
    if (mem[2] !== 32'h8 || rd_cnt != r0 || wr_cnt - w0 != 1 || last_wr_addr !== 32'd2) begin
      errors++;
      $display("FAIL word_store: mem[2]=%h reads=%0d writes=%0d addr=%h, required 8 0 1 2",
               mem[2], rd_cnt - r0, wr_cnt - w0, last_wr_addr);
    end
    issue(1'b0, 2'b10, 1'b1, 32'd8, 32'h0, 32'h0000_0008, 1'b0, 3);
  endtask

  task automatic test_misaligned();
    int r0;
    int w0;
    r0 = rd_cnt; w0 = wr_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'd5, 32'h0, last_load, 1'b1, 1);
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL trap_no_access: reads=%0d writes=%0d, required 0 0", rd_cnt - r0, wr_cnt - w0);
    end
    issue(1'b0, 2'b01, 1'b1, 32'd7, 32'h0, last_load, 1'b1, 1);
`else
    issue(1'b0, 2'b10, 1'b0, 32'd5, 32'h0, 32'h8000_BEEF, 1'b0, 3);
    checks++;
    if (rd_cnt - r0 != 2 || wr_cnt != w0) begin
      errors++;
      $display("FAIL misaligned_access: reads=%0d writes=%0d, required 2 0", rd_cnt - r0, wr_cnt - w0);
    end
    issue(1'b0, 2'b01, 1'b1, 32'd7, 32'h0, 32'hFFFF_BEEF, 1'b0, 3);
`endif
  endtask

  task automatic test_byte_store();
    issue(1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_55AA, last_load, 1'b0, 4);
    checks++;
    if (mem[1] !== 32'h80AA_BEEF) begin
      errors++;
      $display("FAIL byte_store: mem[1]=%h, required 80aabeef", mem[1]);
    end
    issue(1'b0, 2'b01, 1'b0, 32'd4, 32'h0, 32'h0000_80AA, 1'b0, 3);
    issue(1'b0, 2'b11, 1'b1, 32'd4, 32'h0, 32'h80AA_BEEF, 1'b0, 3);
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   d0;
    int   w0;
    d0 = done_cnt; w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; byte_addr = 32'd4;
    e.ld = 32'h80AA_BEEF; e.mis = 1'b0; e.cyc = cyc + 3;
    sb_q.push_back(e);
    last_load = e.ld;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%0b, required 1", busy);
    end
    start = 1'b1; is_store = 1'b1; size = 2'b10; byte_addr = 32'd0; store_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || wr_cnt != w0 || mem[0] !== 32'h0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL start_while_busy: dones=%0d writes=%0d mem[0]=%h pending=%0d, required 1 0 0 0",
               done_cnt - d0, wr_cnt - w0, mem[0], sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid_store();
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; size = 2'b00; byte_addr = 32'd7; store_data = 32'h0000_0011;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_store: rd/wr/busy/done=%b, required 0000", {mem_read, mem_write, busy, done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_load = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem[1] !== 32'h80AA_BEEF || done_cnt != d0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_store_after: mem[1]=%h dones=%0d ld=%h, required 80aabeef 0 0",
               mem[1], done_cnt - d0, load_data);
    end
    issue(1'b0, 2'b00, 1'b0, 32'd7, 32'h0, 32'h0000_00EF, 1'b0, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_loads();
    test_half_store();
    test_word_store();
    test_misaligned();
    test_byte_store();
    test_start_while_busy();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the MIPS datapath's MEM stage and the word-addressed `memory` block. Accepts one load/store request at a time using byte addresses and byte/half/word sizes. Drives the memory's word address, write data, MemWrite and MemRead. Returns sign- or zero-extended load data, and performs read-modify-write for sub-word stores, since `memory` only writes whole words.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width (fixed at 32; parameter for documentation only)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: request strobe, sampled only in IDLE
- `is_store` in 1: 1 = store, 0 = load
- `size` in 2: 00 byte, 01 half, 10 word, 11 treated as word
- `sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend
- `byte_addr` in ADDR_W: byte address
- `store_data` in 32: right-justified store value
- `busy` out 1: high in every non-IDLE state
- `done` out 1: one-cycle completion pulse
- `load_data` out 32: extended load result, held until next `done`
- `misaligned` out 1: valid with `done`
- `mem_addr` out 32: word address, equal to `byte_addr >> 2`
- `mem_write_data` out 32: to memory write_data
- `mem_write` out 1: to memory MemWrite
- `mem_read` out 1: to memory MemRead
- `mem_read_data` in 32: from memory read_data, valid one cycle after `mem_read`/`mem_addr` are presented

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE with `start`=1: latch all request inputs, then branch:
  - load: go to RD
  - word store: go to WR
  - sub-word store: go to RD
  - misaligned with trap enabled: go to DONE
- `start` outside IDLE is ignored; no queueing.
- RD: `mem_read`=1, `mem_addr` = latched word address. Always goes to CAP.
- CAP: `mem_read` held at 1.
  - Capture `mem_read_data` into the word register.
  - Load: extract and extend, register into `load_data`, go to DONE.
  - Sub-word store: merge the store lane into the word register, go to WR.
- WR: `mem_write`=1 for exactly one cycle, `mem_write_data` = merged or full word. Go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Byte lanes are big-endian:
  - Byte offset 0 maps to bits 31:24 and offset 3 to bits 7:0.
  - Half offset 0 maps to 31:16 and offset 2 to 15:0.
- Extension: byte uses bit 7 of the extracted lane, half uses bit 15. A word load ignores `sign_ext`.
- Sub-word store merge replaces only the addressed lane with `store_data[7:0]` or `store_data[15:0]`; other bytes are preserved.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Latency, with `start` sampled at edge k:
  - load: `done` in cycle k+3
  - word store: `done` in k+2
  - sub-word store: `done` in k+4
  - trapped misaligned access: `done` in k+1, with zero memory activity
- `busy` rises in the cycle after `start` is sampled and falls when DONE returns to IDLE. The earliest next `start` is the cycle after DONE.
- Reset values: state IDLE, and `busy`, `done`, `misaligned`, `mem_write`, `mem_read` all 0. `load_data`, `mem_addr`, `mem_write_data` reset to 0.
- Reset mid-operation: memory strobes drop asynchronously. An in-flight store has written nothing unless it had already reached WR, and no `done` is issued.
- `start` coincident with reset release is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `byte_addr[0]`=1, or a word access with `byte_addr[1:0]`≠0, performs no memory access.
  - It goes IDLE→DONE with `misaligned`=1 and `load_data` unchanged.
- Undefined:
  - Low address bits below natural alignment are ignored: half forces bit 0 to 0, word forces bits 1:0 to 0.
  - The access proceeds normally, and `misaligned` is tied to 0.

## Structure
- Package `lsu_pkg`: state encoding constants, size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), and byte-lane offset constants.
- Sub-module `lsu_lane_align` (combinational) performs lane extraction with extension and lane merge. The FSM, request latches and memory strobes stay in `load_store_unit`.

## Test plan
Memory word 1 is preloaded with 0x800000F0 for the scenarios that use it.
- **Byte loads:** lb with `sign_ext`=1 at byte_addr 7 → `load_data`=0xFFFFFFF0, `done` at k+3. Repeat with `sign_ext`=0 → 0x000000F0.
- **Half store:** sh 0x1234BEEF at byte_addr 6 → RD/CAP/WR sequence, word 1 becomes 0x8000BEEF, `done` at k+4. A following lh at 4 returns 0xFFFF8000.
- **Word store:** sw 0x00000008 at byte_addr 8 → single `mem_write` pulse with `mem_addr`=2, no `mem_read`. A following lw at 8 returns 0x00000008.
- **Misaligned load:** lw at byte_addr 5.
  - With `LSU_MISALIGN_TRAP_EN`: `misaligned`=1, `done` at k+1, `mem_read` never high.
  - Without it: returns word 1.
- **Reset mid-store:** `rst`=0 during CAP of a sub-word store → strobes and `busy` drop immediately, word 1 unchanged, no `done`.
- **Start while busy:** `start` pulsed while `busy` is high → ignored; exactly one `done` observed.
